// File: rtl/auto_bright_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : auto_bright_ctrl
//  Description : Closed-loop exposure controller. Accumulates approximate
//                luma and clipped-pixel count per frame, then divides the
//                luma sum by the pixel count with a serial restoring divider
//                and steps the brightness offset toward a target mean.
//  Revision    : 1.0 - initial release
// ============================================================================
module auto_bright_ctrl #(
    parameter int CNT_W       = 17,
    parameter int SUM_W       = 25,
    parameter int TARGET      = 128,
    parameter int DEADBAND    = 8,
    parameter int STEP        = 4,
    parameter int CLIP_MAX    = 64,
    parameter int BRIGHT_INIT = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       frame_end,
    input  logic       pix_valid,
    input  logic [7:0] rin,
    input  logic [7:0] gin,
    input  logic [7:0] bin,
    input  logic       clip_in,
    output logic [7:0] bright,
    output logic       bright_update,
    output logic [7:0] avg_luma,
    output logic       busy
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_accum  = 2'd1;
    localparam logic [1:0] c_st_divide = 2'd2;
    localparam logic [1:0] c_st_adjust = 2'd3;

    localparam int         c_bc_w      = $clog2(SUM_W);
    localparam logic [c_bc_w-1:0] c_bc_last = c_bc_w'(SUM_W - 1);
    localparam logic [8:0] c_lo        = 9'(TARGET - DEADBAND);
    localparam logic [8:0] c_hi        = 9'(TARGET + DEADBAND);
    localparam logic [8:0] c_step9     = 9'(STEP);
    localparam logic [7:0] c_step8     = 8'(STEP);
    localparam logic [CNT_W-1:0] c_clip_max = CNT_W'(CLIP_MAX);

    logic [1:0]        r_state;
    logic [SUM_W-1:0]  r_sum;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_clip;
    logic [SUM_W-1:0]  r_quo;
    logic [CNT_W-1:0]  r_rem;
    logic [c_bc_w-1:0] r_bitcnt;
    logic [7:0]        r_bright;
    logic [7:0]        r_avg;
    logic              r_update;

    logic              w_take_pix;
    logic              w_clear;
    logic [9:0]        w_luma_sum;
    logic [7:0]        w_luma;
    logic [SUM_W-1:0]  w_sum_base;
    logic [CNT_W-1:0]  w_cnt_base;
    logic [CNT_W-1:0]  w_clip_base;
    logic [SUM_W:0]    w_sum_add;
    logic [CNT_W:0]    w_cnt_add;
    logic [CNT_W:0]    w_clip_add;
    logic [SUM_W-1:0]  w_sum_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [CNT_W-1:0]  w_clip_next;
    logic [CNT_W:0]    w_trial;
    logic              w_fits;
    logic [CNT_W-1:0]  w_rem_next;
    logic [7:0]        w_avg;
    logic [8:0]        w_up;
    logic [7:0]        w_bright_up;
    logic [7:0]        w_bright_dn;
    logic [7:0]        w_bright_adj;

    // A pixel is taken only while accumulating, or on the cycle that opens a frame.
    assign w_take_pix = pix_valid &&
                        (((r_state == c_st_idle) && frame_start) || (r_state == c_st_accum));
    // frame_end outranks a coincident frame_start, so no clear in that case.
    assign w_clear    = ((r_state == c_st_idle) && frame_start) ||
                        ((r_state == c_st_accum) && frame_start && !frame_end);

    assign w_luma_sum = {2'b00, rin} + {1'b0, gin, 1'b0} + {2'b00, bin};
    assign w_luma     = 8'(w_luma_sum >> 2);

    assign w_sum_base  = w_clear ? '0 : r_sum;
    assign w_cnt_base  = w_clear ? '0 : r_cnt;
    assign w_clip_base = w_clear ? '0 : r_clip;

    assign w_sum_add  = {1'b0, w_sum_base} + {{(SUM_W-7){1'b0}}, w_luma};
    assign w_cnt_add  = {1'b0, w_cnt_base} + (CNT_W+1)'(1);
    assign w_clip_add = {1'b0, w_clip_base} + {{CNT_W{1'b0}}, clip_in};

    // Saturating accumulators: carry out pins the value at all-ones.
    assign w_sum_next  = !w_take_pix ? w_sum_base :
                         (w_sum_add[SUM_W] ? '1 : w_sum_add[SUM_W-1:0]);
    assign w_cnt_next  = !w_take_pix ? w_cnt_base :
                         (w_cnt_add[CNT_W] ? '1 : w_cnt_add[CNT_W-1:0]);
    assign w_clip_next = !w_take_pix ? w_clip_base :
                         (w_clip_add[CNT_W] ? '1 : w_clip_add[CNT_W-1:0]);

    // Restoring divider step: dividend bits shift out of r_quo MSB, quotient bits in at LSB.
    assign w_trial    = {r_rem, r_quo[SUM_W-1]};
    assign w_fits     = (w_trial >= {1'b0, r_cnt});
    assign w_rem_next = w_fits ? CNT_W'(w_trial - {1'b0, r_cnt}) : CNT_W'(w_trial);

    assign w_avg       = (|r_quo[SUM_W-1:8]) ? 8'hFF : r_quo[7:0];
    assign w_up        = {1'b0, r_bright} + c_step9;
    assign w_bright_up = w_up[8] ? 8'hFF : w_up[7:0];
    assign w_bright_dn = (r_bright < c_step8) ? 8'h00 : (r_bright - c_step8);

    // Priority-ordered brightness decision: clipping first, then dark, then bright.
    always_comb begin
        w_bright_adj = r_bright;
        if (r_clip > c_clip_max) begin
            w_bright_adj = w_bright_dn;
        end else if ({1'b0, w_avg} < c_lo) begin
            w_bright_adj = w_bright_up;
        end else if ({1'b0, w_avg} > c_hi) begin
            w_bright_adj = w_bright_dn;
        end
    end

    // Frame controller: accumulate, divide, adjust, with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_sum    <= '0;
            r_cnt    <= '0;
            r_clip   <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_bitcnt <= '0;
            r_bright <= 8'(BRIGHT_INIT);
            r_avg    <= 8'h00;
            r_update <= 1'b0;
        end else begin
            r_update <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (frame_start) begin
                        r_sum   <= w_sum_next;
                        r_cnt   <= w_cnt_next;
                        r_clip  <= w_clip_next;
                        r_state <= c_st_accum;
                    end
                end
                c_st_accum: begin
                    r_sum  <= w_sum_next;
                    r_cnt  <= w_cnt_next;
                    r_clip <= w_clip_next;
                    if (frame_end) begin
                        if (w_cnt_next == '0) begin
                            r_state <= c_st_idle;
                        end else begin
                            r_quo    <= w_sum_next;
                            r_rem    <= '0;
                            r_bitcnt <= '0;
                            r_state  <= c_st_divide;
                        end
                    end
                end
                c_st_divide: begin
                    r_quo    <= {r_quo[SUM_W-2:0], w_fits};
                    r_rem    <= w_rem_next;
                    r_bitcnt <= r_bitcnt + c_bc_w'(1);
                    if (r_bitcnt == c_bc_last) begin
                        r_state <= c_st_adjust;
                    end
                end
                c_st_adjust: begin
                    r_bright <= w_bright_adj;
                    r_avg    <= w_avg;
                    r_update <= 1'b1;
                    r_state  <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign bright        = r_bright;
    assign avg_luma      = r_avg;
    assign bright_update = r_update;
    assign busy          = (r_state == c_st_divide) || (r_state == c_st_adjust);

endmodule
`default_nettype wire

// File: tb/tb_auto_bright_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_auto_bright_ctrl
//  Description : Directed self-checking bench for auto_bright_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_auto_bright_ctrl;

    logic       clock;
    logic       reset;
    logic       frame_start;
    logic       frame_end;
    logic       pix_valid;
    logic [7:0] rin;
    logic [7:0] gin;
    logic [7:0] bin;
    logic       clip_in;

    logic [7:0] bright;
    logic       bright_update;
    logic [7:0] avg_luma;
    logic       busy;

    logic [7:0] bright2;
    logic       bright_update2;
    logic [7:0] avg_luma2;
    logic       busy2;

    int total = 0;
    int bad   = 0;

    auto_bright_ctrl #(.CLIP_MAX(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .pix_valid    (pix_valid),
        .rin          (rin),
        .gin          (gin),
        .bin          (bin),
        .clip_in      (clip_in),
        .bright       (bright),
        .bright_update(bright_update),
        .avg_luma     (avg_luma),
        .busy         (busy)
    );

    auto_bright_ctrl #(.BRIGHT_INIT(254)) dut2 (
        .clock        (clock),
        .reset        (reset),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .pix_valid    (pix_valid),
        .rin          (rin),
        .gin          (gin),
        .bin          (bin),
        .clip_in      (clip_in),
        .bright       (bright2),
        .bright_update(bright_update2),
        .avg_luma     (avg_luma2),
        .busy         (busy2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then advance past the next rising edge.
    task automatic pix(input bit fs, input bit fe, input bit pv,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input bit c);
        frame_start = fs;
        frame_end   = fe;
        pix_valid   = pv;
        rin         = r;
        gin         = g;
        bin         = b;
        clip_in     = c;
        tick();
        frame_start = 1'b0;
        frame_end   = 1'b0;
        pix_valid   = 1'b0;
        clip_in     = 1'b0;
    endtask

    // n pixels of one colour, frame_start on the first, frame_end on the last.
    task automatic drive_frame(input int n, input logic [7:0] r, input logic [7:0] g,
                               input logic [7:0] b, input bit c);
        for (int i = 0; i < n; i++) begin
            pix(i == 0, i == n - 1, 1'b1, r, g, b, c);
        end
    endtask

    // Called in cycle T+1 after frame_end at T; checks pulse timing and results.
    task automatic check_result(input string tag, input logic [7:0] exp_bright,
                                input logic [7:0] exp_avg);
        chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
        repeat (25) tick();
        chk({tag, ".early_pulse"}, {31'd0, bright_update}, 32'd0);
        tick();
        chk({tag, ".pulse"}, {31'd0, bright_update}, 32'd1);
        chk({tag, ".bright"}, {24'd0, bright}, {24'd0, exp_bright});
        chk({tag, ".avg"}, {24'd0, avg_luma}, {24'd0, exp_avg});
        tick();
        chk({tag, ".pulse_end"}, {31'd0, bright_update}, 32'd0);
    endtask

    task automatic watch(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bright_update) seen++;
        end
    endtask

    initial begin
        int seen;
        reset       = 1'b1;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        pix_valid   = 1'b0;
        rin         = 8'd0;
        gin         = 8'd0;
        bin         = 8'd0;
        clip_in     = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        chk("rst.bright", {24'd0, bright}, 32'd0);
        chk("rst.avg", {24'd0, avg_luma}, 32'd0);
        chk("rst.update", {31'd0, bright_update}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.bright2", {24'd0, bright2}, 32'd254);

        // luma 100, dark -> step up
        drive_frame(16, 8'd100, 8'd100, 8'd100, 1'b0);
        check_result("grey100", 8'd4, 8'd100);

        // luma (130+240+140)>>2 = 127, inside deadband -> hold
        drive_frame(16, 8'd130, 8'd120, 8'd140, 1'b0);
        check_result("deadband", 8'd4, 8'd127);

        // dark but 8 clipped pixels > 4 -> clip rule steps down
        drive_frame(8, 8'd50, 8'd50, 8'd50, 1'b1);
        check_result("clip", 8'd0, 8'd50);

        // bright frame at bright=0 -> saturates at 0, pulse still issued
        drive_frame(16, 8'd200, 8'd200, 8'd200, 1'b0);
        check_result("sat_low", 8'd0, 8'd200);

        // empty frame -> no divide, no pulse
        pix(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
        pix(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
        chk("empty.busy", {31'd0, busy}, 32'd0);
        watch(40, seen);
        chk("empty.no_pulse", seen, 32'd0);
        chk("empty.avg", {24'd0, avg_luma}, 32'd200);

        // restart mid-frame: black pixels discarded, only four luma-100 pixels count
        pix(1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0);
        for (int i = 0; i < 7; i++) pix(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0);
        pix(1'b1, 1'b0, 1'b1, 8'd100, 8'd100, 8'd100, 1'b0);
        pix(1'b0, 1'b0, 1'b1, 8'd100, 8'd100, 8'd100, 1'b0);
        pix(1'b0, 1'b0, 1'b1, 8'd100, 8'd100, 8'd100, 1'b0);
        pix(1'b0, 1'b1, 1'b1, 8'd100, 8'd100, 8'd100, 1'b0);
        check_result("restart", 8'd4, 8'd100);

        // a whole frame presented while busy is dropped
        drive_frame(4, 8'd100, 8'd100, 8'd100, 1'b0);
        chk("busy_ign.busy", {31'd0, busy}, 32'd1);
        pix(1'b1, 1'b0, 1'b1, 8'd255, 8'd255, 8'd255, 1'b1);
        pix(1'b0, 1'b0, 1'b1, 8'd255, 8'd255, 8'd255, 1'b1);
        pix(1'b0, 1'b1, 1'b1, 8'd255, 8'd255, 8'd255, 1'b1);
        repeat (22) tick();
        chk("busy_ign.early_pulse", {31'd0, bright_update}, 32'd0);
        tick();
        chk("busy_ign.pulse", {31'd0, bright_update}, 32'd1);
        chk("busy_ign.bright", {24'd0, bright}, 32'd8);
        chk("busy_ign.avg", {24'd0, avg_luma}, 32'd100);
        watch(40, seen);
        chk("busy_ign.no_extra", seen, 32'd0);

        // reset in the middle of the divide aborts the update
        drive_frame(4, 8'd100, 8'd100, 8'd100, 1'b0);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_div.bright", {24'd0, bright}, 32'd0);
        chk("rst_div.avg", {24'd0, avg_luma}, 32'd0);
        chk("rst_div.busy", {31'd0, busy}, 32'd0);
        watch(40, seen);
        chk("rst_div.no_pulse", seen, 32'd0);
        chk("rst_div.bright2", {24'd0, bright2}, 32'd254);

        // dark frames from 254: first pulse saturates at 255 and stays there
        for (int k = 0; k < 60; k++) begin
            pix(1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0);
            pix(1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0);
            repeat (26) tick();
            chk("sat_hi.pulse", {31'd0, bright_update2}, 32'd1);
            chk("sat_hi.bright", {24'd0, bright2}, 32'd255);
            tick();
        end
        chk("sat_hi.avg", {24'd0, avg_luma2}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
